ws2812_rx: RTL and testbench
============================

# ws2812_rx

Decoder for a WS2812/NeoPixel single-wire serial stream, the receive end of the LED data line our SPI-to-NeoPixel path drives. It oversamples the line with CLK and classifies each high pulse by width as a 0 or 1 bit. It assembles bits MSB-first into 24-bit GRB words, emits each word with its index in the frame, and reports frame end on the reset (latch) low period. It is used for loopback verification of the LED driver and for daisy-chain capture boards.

## Interface
Parameters:
- SYSTEM_CLOCK, 50000000, CLK frequency in Hz; must be ≥ 20 MHz.
- ADDR_W, 9, width of the word index (matches the 512-word LED buffer).

Derived localparams, integer arithmetic, with C = SYSTEM_CLOCK/1000000 (C=50 at default):
- MIN_HI = C*15/100 (7): minimum legal high width.
- THR = C*6/10 (30): 0/1 decision threshold.
- MAX_HI = C*2 (100): maximum legal high width.
- RST_LO = C*50 (2500): latch low time.

Ports:
- CLK, in, 1: clock.
- RESET, in, 1: synchronous, active-high.
- DI, in, 1: asynchronous serial line, idle low.
- DATA, out, 24: last completed word; first received bit lands in DATA[23] (G7).
- ADDR, out, ADDR_W: index of DATA within the current frame.
- DATA_VALID, out, 1: one-cycle strobe; DATA and ADDR are valid in that cycle.
- FRAME_DONE, out, 1: one-cycle strobe at latch detection.
- FRAME_WORDS, out, 16: count of complete words in the frame just ended; valid with FRAME_DONE.
- ERROR, out, 1: one-cycle strobe on any protocol violation.
- SYNCED, out, 1: high when the decoder is not in SYNC.

## Operation
Input conditioning:
- DI passes through a 2-flop synchronizer (s1, s2), both reset to 0.
- s3 holds the previous s2.
- A rising edge is s2=1 and s3=0; a falling edge is s2=0 and s3=1.

State machine, with one counter sized to hold RST_LO:
- **SYNC** (entered on reset):
  - Count cycles with s2=0; s2=1 clears the count.
  - When the count reaches RST_LO, go to LOW with bit_idx=0 and word_idx=0.
  - No bits are decoded while in SYNC.
- **LOW**:
  - Count low cycles, saturating at RST_LO.
  - On a rising edge, go to HIGH with cnt=1.
  - When cnt first reaches RST_LO and (word_idx≠0 or bit_idx≠0):
    - pulse FRAME_DONE with FRAME_WORDS = word_idx;
    - also pulse ERROR if bit_idx≠0 (partial word, discarded);
    - clear word_idx and bit_idx.
  - Low gaps shorter than RST_LO are never errors.
- **HIGH**:
  - Count high cycles.
  - If cnt reaches MAX_HI while s2=1: pulse ERROR and go to SYNC.
  - On a falling edge with cnt < MIN_HI: pulse ERROR and go to SYNC (glitch).
  - Otherwise on a falling edge: bit = (cnt ≥ THR), shift it into the word register LSB-side, bit_idx+1, go to LOW with cnt=1.
  - When bit_idx reaches 24: DATA ← word, ADDR ← word_idx, pulse DATA_VALID, bit_idx ← 0, word_idx+1.
- On any entry to SYNC, the partial word and indices are discarded and no FRAME_DONE is issued.

Width rules:
- ADDR is word_idx[ADDR_W-1:0] and wraps modulo 2^ADDR_W.
- word_idx itself is 16 bits and saturates at 65535, so FRAME_WORDS saturates.
- DATA and ADDR hold their values between strobes.

## Timing
- Reset values: DATA=0, ADDR=0, DATA_VALID=0, FRAME_DONE=0, FRAME_WORDS=0, ERROR=0, SYNCED=0, state=SYNC. RESET mid-frame aborts the frame silently.
- Pulse width measured in cnt is the number of CLK cycles s2 was high, which is ±1 cycle quantization of the true width.
- Latency: an edge on DI is first sampled at CLK edge k. The resulting strobe (DATA_VALID, ERROR on glitch) is registered at edge k+2 and visible after it.
- The MAX_HI error fires while DI is still high, in the cycle cnt reaches MAX_HI.
- FRAME_DONE fires RST_LO cycles (+2 synchronizer cycles) after the last falling edge.
- Strobe coincidence:
  - ERROR and FRAME_DONE may coincide (partial word).
  - DATA_VALID never coincides with FRAME_DONE.
- SYNCED goes high the cycle after SYNC exits and low the cycle after an error.

## Test plan
All cases run at 50 MHz. Bit 0 is 20 cycles high / 42 low; bit 1 is 40 high / 22 low.
- Reset, DI low 2600 cycles, word 0xFF0055, DI low 2600 -> one DATA_VALID with DATA=0xFF0055, ADDR=0; then FRAME_DONE with FRAME_WORDS=1; ERROR never.
- After reset, send a word with no preceding 2500-cycle low -> no DATA_VALID, SYNCED stays 0; after a 2600-cycle low, SYNCED=1.
- Synced, send 0x123456, 0xABCDEF, 0x000001, then latch -> ADDR 0,1,2 with matching DATA; FRAME_WORDS=3; the next frame restarts at ADDR=0.
- Threshold sweep: high widths 29 vs 30 -> decoded bit 0 vs 1; width 7 decodes and width 6 gives ERROR plus SYNCED low; width 100 gives ERROR while DI is still high.
- 12 bits, then 2600 low -> FRAME_DONE and ERROR in the same cycle, FRAME_WORDS=0, no DATA_VALID.
- RESET asserted mid-word, then a full sync and word 0x00FF00 -> all outputs at reset values during reset; then DATA=0x00FF00, ADDR=0.

Source files
------------

// File: rtl/ws2812_rx_if.sv
// Output bundle of the WS2812 receiver: serial line in, decoded words and
// frame/error strobes out.
interface ws2812_rx_if #(
   parameter int ADDR_W = 9
);
   logic              DI;
   logic [23:0]       DATA;
   logic [ADDR_W-1:0] ADDR;
   logic              DATA_VALID;
   logic              FRAME_DONE;
   logic [15:0]       FRAME_WORDS;
   logic              ERROR;
   logic              SYNCED;

   modport master (
      input  DI,
      output DATA, ADDR, DATA_VALID, FRAME_DONE, FRAME_WORDS, ERROR, SYNCED
   );

   modport slave (
      output DI,
      input  DATA, ADDR, DATA_VALID, FRAME_DONE, FRAME_WORDS, ERROR, SYNCED
   );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 single-wire stream decoder: classifies high-pulse widths into bits,
// assembles 24-bit GRB words MSB-first and flags frame latch and protocol errors.
module ws2812_rx #(
   parameter int SYSTEM_CLOCK = 50000000,
   parameter int ADDR_W       = 9
) (
   input  logic        CLK,
   input  logic        RESET,
   ws2812_rx_if.master bus
);
   localparam int C      = SYSTEM_CLOCK / 1000000;
   localparam int MIN_HI = C * 15 / 100;
   localparam int THR    = C * 6 / 10;
   localparam int MAX_HI = C * 2;
   localparam int RST_LO = C * 50;
   localparam int CW     = $clog2(RST_LO + 1);

   localparam logic [CW-1:0] MIN_HI_C = CW'(MIN_HI);
   localparam logic [CW-1:0] THR_C    = CW'(THR);
   localparam logic [CW-1:0] MAX_HI_C = CW'(MAX_HI);
   localparam logic [CW-1:0] RST_LO_C = CW'(RST_LO);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   typedef enum logic [1:0] {SYNC = 2'd0, LOW = 2'd1, HIGH = 2'd2} state_t;

   state_t        state, state_nxt;
   logic          s1, s2, s3;
   logic          rise;
   logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
   logic [4:0]    bit_idx, bit_idx_nxt;
   logic [15:0]   word_idx, word_idx_nxt;
   logic [23:0]   word, word_shift;
   logic          bit_val, shift_en;
   logic          dv_nxt, fd_nxt, err_nxt;

   assign rise       = s2 & ~s3;
   assign cnt_inc    = cnt + ONE_C;
   assign bit_val    = (cnt >= THR_C);
   assign word_shift = {word[22:0], bit_val};

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         SYNC: if (!s2 && cnt_inc == RST_LO_C) state_nxt = LOW;
         LOW:  if (rise) state_nxt = HIGH;
         HIGH: begin
            if (s2) begin
               if (cnt_inc == MAX_HI_C) state_nxt = SYNC;
            end else if (cnt < MIN_HI_C) begin
               state_nxt = SYNC;
            end else begin
               state_nxt = LOW;
            end
         end
         default: state_nxt = SYNC;
      endcase
   end

   // Counter, index and strobe decisions; in HIGH, s2=0 is always a falling edge
   always_comb begin
      cnt_nxt      = cnt;
      bit_idx_nxt  = bit_idx;
      word_idx_nxt = word_idx;
      shift_en     = 1'b0;
      dv_nxt       = 1'b0;
      fd_nxt       = 1'b0;
      err_nxt      = 1'b0;
      case (state)
         SYNC: begin
            cnt_nxt      = s2 ? '0 : cnt_inc;
            bit_idx_nxt  = '0;
            word_idx_nxt = '0;
         end
         LOW: begin
            if (rise) begin
               cnt_nxt = ONE_C;
            end else if (cnt != RST_LO_C) begin
               cnt_nxt = cnt_inc;
               if (cnt_inc == RST_LO_C && (word_idx != '0 || bit_idx != '0)) begin
                  fd_nxt       = 1'b1;
                  err_nxt      = (bit_idx != '0);
                  bit_idx_nxt  = '0;
                  word_idx_nxt = '0;
               end
            end
         end
         HIGH: begin
            if (s2) begin
               if (cnt_inc == MAX_HI_C) begin
                  err_nxt      = 1'b1;
                  cnt_nxt      = '0;
                  bit_idx_nxt  = '0;
                  word_idx_nxt = '0;
               end else begin
                  cnt_nxt = cnt_inc;
               end
            end else if (cnt < MIN_HI_C) begin
               err_nxt      = 1'b1;
               cnt_nxt      = '0;
               bit_idx_nxt  = '0;
               word_idx_nxt = '0;
            end else begin
               shift_en = 1'b1;
               cnt_nxt  = ONE_C;
               if (bit_idx == 5'd23) begin
                  dv_nxt       = 1'b1;
                  bit_idx_nxt  = '0;
                  word_idx_nxt = (word_idx == 16'hFFFF) ? word_idx : word_idx + 16'd1;
               end else begin
                  bit_idx_nxt = bit_idx + 5'd1;
               end
            end
         end
         default: begin
            cnt_nxt      = '0;
            bit_idx_nxt  = '0;
            word_idx_nxt = '0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1              <= 1'b0;
         s2              <= 1'b0;
         s3              <= 1'b0;
         state           <= SYNC;
         cnt             <= '0;
         bit_idx         <= '0;
         word_idx        <= '0;
         bus.DATA        <= '0;
         bus.ADDR        <= '0;
         bus.DATA_VALID  <= 1'b0;
         bus.FRAME_DONE  <= 1'b0;
         bus.FRAME_WORDS <= '0;
         bus.ERROR       <= 1'b0;
         bus.SYNCED      <= 1'b0;
      end else begin
         s1             <= bus.DI;
         s2             <= s1;
         s3             <= s2;
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         bit_idx        <= bit_idx_nxt;
         word_idx       <= word_idx_nxt;
         bus.DATA_VALID <= dv_nxt;
         bus.FRAME_DONE <= fd_nxt;
         bus.ERROR      <= err_nxt;
         bus.SYNCED     <= (state_nxt != SYNC);
         if (fd_nxt) bus.FRAME_WORDS <= word_idx;
         if (dv_nxt) begin
            bus.DATA <= word_shift;
            bus.ADDR <= word_idx[ADDR_W-1:0];
         end
      end
   end

   // Shift register carries no control meaning, so it is left unreset
   always_ff @(posedge CLK) begin
      if (shift_en) word <= word_shift;
   end
endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives DI as level segments and compares the observed
// strobe stream against an event-level model of the decoding rules.
module tb_ws2812_rx;
   localparam int SYSTEM_CLOCK = 50000000;
   localparam int ADDR_W       = 9;
   localparam int C            = SYSTEM_CLOCK / 1000000;
   localparam int MIN_HI       = C * 15 / 100;
   localparam int THR          = C * 6 / 10;
   localparam int MAX_HI       = C * 2;
   localparam int RST_LO       = C * 50;
   localparam int LATCH        = 2600;

   typedef struct packed {
      logic [1:0]  kind;
      logic [23:0] data;
      logic [15:0] aux;
   } ev_t;
   localparam logic [1:0] EV_DV = 2'd1, EV_FD = 2'd2, EV_ERR = 2'd3;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   int   errors = 0;
   int   checks = 0;
   ev_t  obs_q[$];
   ev_t  exp_q[$];
   bit   fd_err_same, err_while_high, synced_seen;

   int          m_synced, m_lowacc, m_bits, m_words;
   logic [23:0] m_word;

   ws2812_rx_if #(.ADDR_W(ADDR_W)) bus();
   ws2812_rx #(.SYSTEM_CLOCK(SYSTEM_CLOCK), .ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RESET(RESET), .bus(bus)
   );

   always #10 CLK = ~CLK;

   function automatic ev_t mk(input logic [1:0] k, input logic [23:0] d, input logic [15:0] a);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.aux  = a;
      return e;
   endfunction

   always @(negedge CLK) begin
      if (!RESET) begin
         if (bus.DATA_VALID === 1'b1) obs_q.push_back(mk(EV_DV, bus.DATA, 16'(bus.ADDR)));
         if (bus.FRAME_DONE === 1'b1) obs_q.push_back(mk(EV_FD, 24'd0, bus.FRAME_WORDS));
         if (bus.ERROR === 1'b1) begin
            obs_q.push_back(mk(EV_ERR, 24'd0, 16'd0));
            if (bus.DI === 1'b1) err_while_high = 1'b1;
         end
         if (bus.FRAME_DONE === 1'b1 && bus.ERROR === 1'b1) fd_err_same = 1'b1;
         if (bus.SYNCED === 1'b1) synced_seen = 1'b1;
      end
   end

   // Reference model: consumes whole DI segments and applies the decoding rules
   task automatic model_reset();
      m_synced = 0;
      m_lowacc = 0;
      m_bits   = 0;
      m_words  = 0;
   endtask

   task automatic model_seg(input logic lvl, input int n);
      if (!lvl) begin
         if (m_synced == 0) begin
            m_lowacc += n;
            if (m_lowacc >= RST_LO) begin
               m_synced = 1;
               m_bits   = 0;
               m_words  = 0;
            end
         end else if (n >= RST_LO && (m_words != 0 || m_bits != 0)) begin
            exp_q.push_back(mk(EV_FD, 24'd0, 16'(m_words)));
            if (m_bits != 0) exp_q.push_back(mk(EV_ERR, 24'd0, 16'd0));
            m_words = 0;
            m_bits  = 0;
         end
      end else if (m_synced == 0) begin
         m_lowacc = 0;
      end else if (n >= MAX_HI || n < MIN_HI) begin
         exp_q.push_back(mk(EV_ERR, 24'd0, 16'd0));
         m_synced = 0;
         m_lowacc = (n < MIN_HI) ? -1 : 0;
      end else begin
         m_word = {m_word[22:0], (n >= THR)};
         m_bits++;
         if (m_bits == 24) begin
            exp_q.push_back(mk(EV_DV, m_word, 16'(m_words % (1 << ADDR_W))));
            m_bits = 0;
            if (m_words < 65535) m_words++;
         end
      end
   endtask

   task automatic seg(input logic lvl, input int n);
      model_seg(lvl, n);
      bus.DI = lvl;
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_bit(input logic b);
      seg(1'b1, b ? 40 : 20);
      seg(1'b0, b ? 22 : 42);
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int i = 23; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic apply_reset();
      RESET  = 1'b1;
      bus.DI = 1'b0;
      repeat (4) @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.DI = i[0];
         @(negedge CLK);
      end
      bus.DI = 1'b0;
      checks += 7;
      if (bus.DATA !== 24'd0) begin errors++; $display("FAIL reset_data: got %h, expected 0", bus.DATA); end
      if (bus.ADDR !== '0) begin errors++; $display("FAIL reset_addr: got %0d, expected 0", bus.ADDR); end
      if (bus.DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b, expected 0", bus.DATA_VALID); end
      if (bus.FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_fd: got %b, expected 0", bus.FRAME_DONE); end
      if (bus.FRAME_WORDS !== 16'd0) begin errors++; $display("FAIL reset_fw: got %0d, expected 0", bus.FRAME_WORDS); end
      if (bus.ERROR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", bus.ERROR); end
      if (bus.SYNCED !== 1'b0) begin errors++; $display("FAIL reset_synced: got %b, expected 0", bus.SYNCED); end
   endtask

   task automatic test_basic();
      apply_reset();
      seg(1'b0, LATCH);
      send_word(24'hFF0055);
      seg(1'b0, LATCH);
      repeat (4) @(negedge CLK);
      checks++;
      if (obs_q.size() < 1 || obs_q[0] !== mk(EV_DV, 24'hFF0055, 16'd0)) begin
         errors++;
         $display("FAIL basic_word: got %0d events, first data=%h, expected DATA=ff0055 ADDR=0",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 24'd0);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL basic_ev%0d: got kind=%0d data=%h aux=%0d, expected kind=%0d data=%h aux=%0d",
                     i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
         end
      end
   endtask

   task automatic test_unsynced();
      apply_reset();
      synced_seen = 1'b0;
      seg(1'b0, 100);
      send_word(24'hA5A5A5);
      checks++;
      if (synced_seen !== 1'b0) begin errors++; $display("FAIL unsync_synced: got SYNCED high, expected 0"); end
      seg(1'b0, LATCH);
      checks++;
      if (bus.SYNCED !== 1'b1) begin errors++; $display("FAIL unsync_resync: got SYNCED=%b, expected 1", bus.SYNCED); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL unsync_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL unsync_ev%0d: got kind=%0d data=%h aux=%0d, expected kind=%0d data=%h aux=%0d",
                     i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
         end
      end
   endtask

   task automatic test_multi();
      apply_reset();
      seg(1'b0, LATCH);
      send_word(24'h123456);
      send_word(24'hABCDEF);
      send_word(24'h000001);
      seg(1'b0, LATCH);
      send_word(24'h777777);
      seg(1'b0, LATCH);
      repeat (4) @(negedge CLK);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL multi_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL multi_ev%0d: got kind=%0d data=%h aux=%0d, expected kind=%0d data=%h aux=%0d",
                     i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
         end
      end
   endtask

   task automatic test_threshold();
      apply_reset();
      seg(1'b0, LATCH);
      seg(1'b1, THR - 1); seg(1'b0, 30);
      seg(1'b1, THR);     seg(1'b0, 30);
      seg(1'b1, MIN_HI);  seg(1'b0, 30);
      for (int i = 0; i < 21; i++) send_bit(1'b1);
      checks++;
      if (obs_q.size() < 1 || obs_q[0].data !== 24'h5FFFFF) begin
         errors++;
         $display("FAIL thr_word: got %0d events, first data=%h, expected 5fffff",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 24'd0);
      end
      seg(1'b1, MIN_HI - 1);
      seg(1'b0, 10);
      checks++;
      if (bus.SYNCED !== 1'b0) begin errors++; $display("FAIL thr_glitch_synced: got %b, expected 0", bus.SYNCED); end
      seg(1'b0, LATCH);
      seg(1'b1, MAX_HI);
      seg(1'b0, LATCH);
      err_while_high = 1'b0;
      seg(1'b1, MAX_HI + 20);
      checks++;
      if (err_while_high !== 1'b1) begin errors++; $display("FAIL thr_maxhi_early: got no ERROR while DI high, expected one"); end
      seg(1'b0, 20);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL thr_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL thr_ev%0d: got kind=%0d data=%h aux=%0d, expected kind=%0d data=%h aux=%0d",
                     i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
         end
      end
   endtask

   task automatic test_partial();
      apply_reset();
      fd_err_same = 1'b0;
      seg(1'b0, LATCH);
      for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(0, 1)));
      seg(1'b0, LATCH);
      repeat (4) @(negedge CLK);
      checks++;
      if (fd_err_same !== 1'b1) begin errors++; $display("FAIL partial_coincide: got FRAME_DONE and ERROR apart, expected same cycle"); end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL partial_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL partial_ev%0d: got kind=%0d data=%h aux=%0d, expected kind=%0d data=%h aux=%0d",
                     i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
         end
      end
   endtask

   task automatic test_random();
      logic [23:0] w;
      int          hi;
      apply_reset();
      seg(1'b0, LATCH);
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
            w = 24'($urandom);
            for (int i = 23; i >= 0; i--) begin
               hi = w[i] ? int'($urandom_range(THR, MAX_HI - 1)) : int'($urandom_range(MIN_HI, THR - 1));
               seg(1'b1, hi);
               seg(1'b0, int'($urandom_range(3, 60)));
            end
         end
         seg(1'b0, LATCH);
         if ($urandom_range(0, 2) == 0) begin
            seg(1'b1, int'($urandom_range(1, MIN_HI - 1)));
            seg(1'b0, LATCH);
         end
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random_ev%0d: got kind=%0d data=%h aux=%0d, expected kind=%0d data=%h aux=%0d",
                     i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      seg(1'b0, LATCH);
      send_word(24'h0F0F0F);
      for (int i = 0; i < 10; i++) send_bit(1'b1);
      bus.DI = 1'b1;
      repeat (10) @(negedge CLK);
      RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if ({bus.DATA, bus.ADDR, bus.DATA_VALID, bus.FRAME_DONE, bus.FRAME_WORDS, bus.ERROR, bus.SYNCED} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs: got DATA=%h ADDR=%0d DV=%b FD=%b FW=%0d ERR=%b SYNCED=%b, expected all 0",
                  bus.DATA, bus.ADDR, bus.DATA_VALID, bus.FRAME_DONE, bus.FRAME_WORDS, bus.ERROR, bus.SYNCED);
      end
      apply_reset();
      seg(1'b0, LATCH);
      send_word(24'h00FF00);
      seg(1'b0, LATCH);
      repeat (4) @(negedge CLK);
      checks++;
      if (obs_q.size() < 1 || obs_q[0] !== mk(EV_DV, 24'h00FF00, 16'd0)) begin
         errors++;
         $display("FAIL midreset_word: got %0d events, first data=%h, expected DATA=00ff00 ADDR=0",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 24'd0);
      end
      checks++;
      if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midreset_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midreset_ev%0d: got kind=%0d data=%h aux=%0d, expected kind=%0d data=%h aux=%0d",
                     i, obs_q[i].kind, obs_q[i].data, obs_q[i].aux, exp_q[i].kind, exp_q[i].data, exp_q[i].aux);
         end
      end
   endtask

   initial begin
      bus.DI = 1'b0;
      @(negedge CLK);
      test_reset();
      test_basic();
      test_unsynced();
      test_multi();
      test_threshold();
      test_partial();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
